apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: arbitrates req0/req1 and runs one SETUP/ACCESS transfer at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; the default build uses fixed priority (requester 0 wins).
module apb_req_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q;
  logic                grant_q;
  logic                done0_q, done1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q, psel_q, penable_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic                elig0, elig1, win1;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A requester whose done pulse is high this cycle still shows its old request.
  assign elig0 = req0 & ~done0_q;
  assign elig1 = req1 & ~done1_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  assign win1 = elig1 & (~elig0 | ~last_q);
`else
  assign win1 = elig1 & ~elig0;
`endif

  assign sel_wr    = win1 ? wr1    : wr0;
  assign sel_addr  = win1 ? addr1  : addr0;
  assign sel_wdata = win1 ? wdata1 : wdata0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (elig0 | elig1) begin
            grant_q  <= win1;
            pwrite_q <= sel_wr;
            paddr_q  <= sel_addr;
            if (sel_wr) pwdata_q <= sel_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= win1;
`endif
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
            if (grant_q) begin
              done1_q <= 1'b1;
              if (!pwrite_q) rdata1_q <= prdata;
            end else begin
              done0_q <= 1'b1;
              if (!pwrite_q) rdata0_q <= prdata;
            end
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = (state_q != IDLE);
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: table of single-requester transfers,
// then stall, stale-request, reset-in-ACCESS and tie sequences against a scoreboard queue.
module tb_apb_req_arbiter;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       req0, req1, wr0, wr1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       busy;
  logic [3:0] paddr;
  logic       pwrite, psel, penable;
  logic [7:0] pwdata, prdata;
  logic       pready;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // Behavioural APB slave with a programmable number of wait cycles
  logic [7:0] mem [16];
  int wait_cfg;
  int wait_cnt = 0;
  assign pready = psel & penable & (wait_cnt >= wait_cfg);
  assign prdata = mem[paddr];
  always @(posedge pclk) begin
    if (psel & penable & !pready) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
    if (psel & penable & pready & pwrite) mem[paddr] <= pwdata;
  end

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    bit r0; bit r1; bit w0; bit w1;
    logic [3:0] a0; logic [3:0] a1;
    logic [7:0] d0; logic [7:0] d1;
    int waits; bit g; logic [7:0] rd;
  } vec_t;

  typedef struct {
    bit g; bit wr; logic [3:0] addr; logic [7:0] wdata; logic [7:0] rd;
    int lat; int start;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] m_rdata0, m_rdata1, m_pwdata;
  logic [3:0] cap_addr;
  logic       cap_wr;
  logic [7:0] cap_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit who, bit wr, logic [3:0] a, logic [7:0] d, int waits, logic [7:0] rd);
    vec_t v;
    v.r0 = !who; v.r1 = who; v.w0 = wr; v.w1 = wr;
    v.a0 = a; v.a1 = a; v.d0 = d; v.d1 = d;
    v.waits = waits; v.g = who; v.rd = rd;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.g     = v.g;
    e.wr    = v.g ? v.w1 : v.w0;
    e.addr  = v.g ? v.a1 : v.a0;
    e.wdata = v.g ? v.d1 : v.d0;
    e.rd    = v.rd;
    e.lat   = 3 + v.waits;
    e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; wr0 = v.w0; wr1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    wait_cfg = v.waits;
    push_exp(v);
  endtask

  task automatic await_done(input bit hold);
    exp_t e;
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge pclk);
      if (psel & penable & pready) begin
        cap_addr = paddr; cap_wr = pwrite; cap_wdata = pwdata;
      end
      if (done0 | done1) seen = 1'b1;
    end
    if (!seen || sb.size() == 0) begin
      check("done_timeout", {31'd0, seen}, 32'd1);
      if (sb.size() != 0) sb.delete(0);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    e = sb.pop_front();
    check("done_who", {done1, done0}, e.g ? 2'b10 : 2'b01);
    check("latency", cyc - e.start, e.lat);
    check("paddr", cap_addr, e.addr);
    check("pwrite", cap_wr, e.wr);
    check("pwdata", cap_wdata, e.wr ? e.wdata : m_pwdata);
    if (e.wr) m_pwdata = e.wdata;
    else if (e.g) m_rdata1 = e.rd;
    else m_rdata0 = e.rd;
    check("rdata0", rdata0, m_rdata0);
    check("rdata1", rdata1, m_rdata1);
    $display("xfer grant=%0d wr=%0d addr=%0h wdata=%0h rdata0=%0h rdata1=%0h lat=%0d",
             e.g, e.wr, e.addr, e.wdata, rdata0, rdata1, cyc - e.start);
    if (!hold) begin
      req0 = 1'b0; req1 = 1'b0;
      @(negedge pclk);
      check("done_pulse", {done1, done0}, 2'b00);
      check("psel_idle", psel, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    bit in_acc;

    rst_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    wait_cfg = 0;
    m_rdata0 = 0; m_rdata1 = 0; m_pwdata = 0;
    cap_addr = 0; cap_wr = 0; cap_wdata = 0;

    repeat (3) @(negedge pclk);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 4'h0);
    check("rst_pwdata", pwdata, 8'h00);
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_rdata", {rdata1, rdata0}, 16'h0000);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge pclk);

    tbl[0] = mk(1'b0, 1'b1, 4'h3, 8'hA5, 1, 8'h00);
    tbl[1] = mk(1'b1, 1'b0, 4'h3, 8'h00, 0, 8'hA5);
    tbl[2] = mk(1'b1, 1'b1, 4'h7, 8'h3C, 0, 8'h00);
    tbl[3] = mk(1'b0, 1'b0, 4'h7, 8'h00, 2, 8'h3C);
    tbl[4] = mk(1'b0, 1'b1, 4'hF, 8'hFF, 0, 8'h00);
    tbl[5] = mk(1'b1, 1'b0, 4'hF, 8'h00, 1, 8'hFF);
    tbl[6] = mk(1'b1, 1'b1, 4'h0, 8'h5A, 3, 8'h00);
    tbl[7] = mk(1'b0, 1'b0, 4'h0, 8'h00, 0, 8'h5A);
    tbl[8] = mk(1'b0, 1'b0, 4'h3, 8'h00, 0, 8'hA5);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      await_done(1'b0);
    end

    // Stall: five wait cycles, requester changes its inputs mid-transfer
    v = mk(1'b1, 1'b1, 4'h9, 8'h77, 5, 8'h00);
    drive(v);
    @(negedge pclk);
    check("stall_setup", {psel, penable}, 2'b10);
    addr1 = 4'h2; wr1 = 1'b0; wdata1 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("stall_hold", {psel, penable, pwrite, paddr, pwdata}, {2'b11, 1'b1, 4'h9, 8'h77});
      check("stall_nodone", {done1, done0}, 2'b00);
    end
    await_done(1'b0);

    // Stale request: req0 stays high through its done cycle
    v = mk(1'b0, 1'b1, 4'h1, 8'h11, 0, 8'h00);
    drive(v);
    await_done(1'b1);
    @(negedge pclk);
    check("stale_no_regrant", psel, 1'b0);
    check("stale_busy", busy, 1'b0);
    push_exp(v);
    @(negedge pclk);
    check("stale_regrant", psel, 1'b1);
    req0 = 1'b0;
    await_done(1'b0);

    // Reset asserted while stuck in ACCESS
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h3; wait_cfg = 200;
    in_acc = 1'b0;
    for (int k = 0; k < 10 && !in_acc; k++) begin
      @(negedge pclk);
      if (psel & penable) in_acc = 1'b1;
    end
    check("rst_reach_access", {31'd0, in_acc}, 32'd1);
    @(negedge pclk);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {psel, penable, busy}, 3'b000);
    req0 = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      check("rst_nodone", {done1, done0}, 2'b00);
    end
    rst_n = 1'b1;
    wait_cfg = 0;
    m_rdata0 = 0; m_rdata1 = 0; m_pwdata = 0;
    repeat (2) begin
      @(negedge pclk);
      check("post_rst_idle", {done1, done0, psel}, 3'b000);
    end
    v = mk(1'b0, 1'b1, 4'h4, 8'hC3, 0, 8'h00);
    drive(v);
    await_done(1'b0);

    // Ties: fresh reset so the round-robin pointer starts at 1
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    m_rdata0 = 0; m_rdata1 = 0; m_pwdata = 0;
    @(negedge pclk);
    for (int r = 0; r < 4; r++) begin
      v.r0 = 1'b1; v.r1 = 1'b1; v.w0 = 1'b1; v.w1 = 1'b1;
      v.a0 = 4'hA; v.a1 = 4'hB;
      v.d0 = 8'h10 + 8'(r); v.d1 = 8'h20 + 8'(r);
      v.waits = 0; v.rd = 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
      v.g = (r % 2) == 1;
`else
      v.g = 1'b0;
`endif
      drive(v);
      await_done(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
